// File: rtl/main_controller_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | main_controller_pkg                                                  |
// | Shared FSM state encoding, selector codes and interval defaults.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package main_controller_pkg;

    typedef enum logic [2:0] {
        MAIN_G1 = 3'd0,
        MAIN_G2 = 3'd1,
        MAIN_Y  = 3'd2,
        WALK    = 3'd3,
        SIDE_G  = 3'd4,
        SIDE_Y  = 3'd5
    } ctrlState_t;

    localparam logic [1:0] SEL_BASE = 2'b00;
    localparam logic [1:0] SEL_EXT  = 2'b01;
    localparam logic [1:0] SEL_YEL  = 2'b10;

    localparam logic [3:0] DEF_T_BASE = 4'd6;
    localparam logic [3:0] DEF_T_EXT  = 4'd3;
    localparam logic [3:0] DEF_T_YEL  = 4'd2;

    // A zero-length interval would never expire, so it is stored as one second.
    function automatic logic [3:0] clampInterval(input logic [3:0] value);
        return (value == 4'd0) ? 4'd1 : value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/main_controller_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | traffic_timer                                                        |
// | One-second tick divider plus seconds counter with expiry compare.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module traffic_timer #(
    parameter int TICK_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] duration,
    output logic       expired,
    output logic [3:0] seconds
);

    localparam int             DIV_W    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_CYCLES - 1);

    logic [DIV_W-1:0] r_div;
    logic [3:0]       r_secs;
    logic             w_tick;

    assign w_tick  = (r_div == DIV_LAST);
    // Expire on the tick that would bring the count up to the duration.
    assign expired = w_tick && (({1'b0, r_secs} + 5'd1) == {1'b0, duration});
    assign seconds = r_secs;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div  <= '0;
            r_secs <= '0;
        end else if (start) begin
            r_div  <= '0;
            r_secs <= '0;
        end else if (w_tick) begin
            r_div  <= '0;
            r_secs <= r_secs + 4'd1;
        end else begin
            r_div  <= r_div + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/main_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | main_controller                                                      |
// | Intersection light sequencer; WALK_EN compiles in the walk phase.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module main_controller
    import main_controller_pkg::*;
#(
    parameter int         TICK_CYCLES = 4,
    parameter logic [3:0] T_BASE_DEF  = DEF_T_BASE,
    parameter logic [3:0] T_EXT_DEF   = DEF_T_EXT,
    parameter logic [3:0] T_YEL_DEF   = DEF_T_YEL
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       trafficSensor,
    input  logic       walkRequest,
    input  logic       reprogram,
    input  logic [1:0] timeSelector,
    input  logic [3:0] timeValue,
    output logic       redMain,
    output logic       yellowMain,
    output logic       greenMain,
    output logic       redSide,
    output logic       yellowSide,
    output logic       greenSide,
    output logic       walkLight
);

    ctrlState_t r_state, w_stateNext;
    logic [1:0] r_sensorSync, r_reprogSync;
    logic       r_reprogPrev;
    logic [3:0] r_tBase, r_tExt, r_tYel;
    logic       r_g2Long, r_sideExt;
    logic       w_sensor, w_load, w_start, w_extend, w_expired, w_walkPending;
    logic [3:0] w_duration, w_seconds;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sensorSync <= '0;
            r_reprogSync <= '0;
            r_reprogPrev <= 1'b0;
        end else begin
            r_sensorSync <= {r_sensorSync[0], trafficSensor};
            r_reprogSync <= {r_reprogSync[0], reprogram};
            r_reprogPrev <= r_reprogSync[1];
        end
    end

    assign w_sensor = r_sensorSync[1];
    assign w_load   = r_reprogSync[1] & ~r_reprogPrev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tBase <= T_BASE_DEF;
            r_tExt  <= T_EXT_DEF;
            r_tYel  <= T_YEL_DEF;
        end else if (w_load) begin
            case (timeSelector)
                SEL_BASE: r_tBase <= clampInterval(timeValue);
                SEL_EXT:  r_tExt  <= clampInterval(timeValue);
                SEL_YEL:  r_tYel  <= clampInterval(timeValue);
                default:  ;
            endcase
        end
    end

`ifdef WALK_EN
    logic [1:0] r_walkSync;
    logic       r_walkPending;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_walkSync    <= '0;
            r_walkPending <= 1'b0;
        end else begin
            r_walkSync <= {r_walkSync[0], walkRequest};
            if (w_start && (w_stateNext == WALK))
                r_walkPending <= 1'b0;
            else if (r_walkSync[1])
                r_walkPending <= 1'b1;
        end
    end

    assign w_walkPending = r_walkPending;
    assign walkLight     = (r_state == WALK);
`else
    logic w_unusedWalk;
    assign w_unusedWalk  = walkRequest;
    assign w_walkPending = 1'b0;
    assign walkLight     = 1'b0;
`endif

    always_comb begin
        w_duration = r_tBase;
        case (r_state)
            MAIN_G2: w_duration = r_g2Long ? r_tExt : r_tBase;
            MAIN_Y:  w_duration = r_tYel;
            WALK:    w_duration = r_tExt;
            SIDE_G:  w_duration = r_sideExt ? r_tExt : r_tBase;
            SIDE_Y:  w_duration = r_tYel;
            default: w_duration = r_tBase;
        endcase
    end

    always_comb begin
        w_stateNext = r_state;
        w_start     = 1'b0;
        w_extend    = 1'b0;
        if (w_load) begin
            w_stateNext = MAIN_G1;
            w_start     = 1'b1;
        end else if (w_expired) begin
            w_start = 1'b1;
            case (r_state)
                MAIN_G1: w_stateNext = MAIN_G2;
                MAIN_G2: w_stateNext = MAIN_Y;
                MAIN_Y:  w_stateNext = w_walkPending ? WALK : SIDE_G;
                WALK:    w_stateNext = SIDE_G;
                SIDE_G: begin
                    if (!r_sideExt && w_sensor) w_extend    = 1'b1;
                    else                        w_stateNext = SIDE_Y;
                end
                default: w_stateNext = MAIN_G1;
            endcase
        end
    end

    // The sensor is also accepted during the first second of MAIN_G2 so a car
    // arriving right at entry is not lost to synchronizer latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= MAIN_G1;
            r_sideExt <= 1'b0;
            r_g2Long  <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            if (w_start) begin
                r_sideExt <= w_extend;
                r_g2Long  <= (w_stateNext == MAIN_G2) && w_sensor;
            end else if ((r_state == MAIN_G2) && (w_seconds == 4'd0) && w_sensor) begin
                r_g2Long  <= 1'b1;
            end
        end
    end

    traffic_timer #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .start   (w_start),
        .duration(w_duration),
        .expired (w_expired),
        .seconds (w_seconds)
    );

    always_comb begin
        redMain    = 1'b0;
        yellowMain = 1'b0;
        greenMain  = 1'b0;
        redSide    = 1'b0;
        yellowSide = 1'b0;
        greenSide  = 1'b0;
        case (r_state)
            MAIN_G1, MAIN_G2: begin greenMain  = 1'b1; redSide    = 1'b1; end
            MAIN_Y:           begin yellowMain = 1'b1; redSide    = 1'b1; end
            SIDE_G:           begin redMain    = 1'b1; greenSide  = 1'b1; end
            SIDE_Y:           begin redMain    = 1'b1; yellowSide = 1'b1; end
            default:          begin redMain    = 1'b1; redSide    = 1'b1; end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_main_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_main_controller                                                   |
// | Directed lamp-sequence and interval-length checks for main_controller|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_main_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       trafficSensor, walkRequest, reprogram;
    logic [1:0] timeSelector;
    logic [3:0] timeValue;
    logic       redMain, yellowMain, greenMain, redSide, yellowSide, greenSide, walkLight;
    logic [6:0] lamps;

    int checks = 0;
    int errors = 0;

    // {redMain, yellowMain, greenMain, redSide, yellowSide, greenSide, walkLight}
    localparam logic [6:0] L_MG = 7'b0011000;
    localparam logic [6:0] L_MY = 7'b0101000;
    localparam logic [6:0] L_WK = 7'b1001001;
    localparam logic [6:0] L_SG = 7'b1000010;
    localparam logic [6:0] L_SY = 7'b1000100;

    main_controller dut (
        .clk          (clk),
        .reset        (reset),
        .trafficSensor(trafficSensor),
        .walkRequest  (walkRequest),
        .reprogram    (reprogram),
        .timeSelector (timeSelector),
        .timeValue    (timeValue),
        .redMain      (redMain),
        .yellowMain   (yellowMain),
        .greenMain    (greenMain),
        .redSide      (redSide),
        .yellowSide   (yellowSide),
        .greenSide    (greenSide),
        .walkLight    (walkLight)
    );

    always #5 clk = ~clk;

    assign lamps = {redMain, yellowMain, greenMain, redSide, yellowSide, greenSide, walkLight};

    task automatic check(input int observed, input int expected, input string tag);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Starting inside the first cycle of a lamp pattern, count how many clocks it holds.
    task automatic runCheck(input logic [6:0] code, input int len, input string tag);
        int n;
        n = 0;
        check(int'(lamps), int'(code), {tag, "_lamps"});
        while ((lamps === code) && (n < 200)) begin
            n++;
            @(posedge clk);
            #1;
        end
        check(n, len, {tag, "_len"});
    endtask

    // Returns inside the first cycle of the MAIN_G1 restart caused by the load.
    task automatic reprog(input logic [1:0] sel, input logic [3:0] val);
        @(negedge clk);
        reprogram    = 1'b1;
        timeSelector = sel;
        timeValue    = val;
        repeat (3) @(posedge clk);
        #2;
        reprogram    = 1'b0;
        timeSelector = 2'b11;
        timeValue    = 4'd0;
    endtask

    initial begin
        reset         = 1'b1;
        trafficSensor = 1'b0;
        walkRequest   = 1'b0;
        reprogram     = 1'b0;
        timeSelector  = 2'b11;
        timeValue     = 4'd0;
        #2;
        check(int'(lamps), int'(L_MG), "reset_lamps");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;

        // Default cycle: 48 + 8 + 24 + 8 = 88 clocks
        runCheck(L_MG, 48, "def_g");
        runCheck(L_MY, 8,  "def_y");
        runCheck(L_SG, 24, "def_sg");
        runCheck(L_SY, 8,  "def_sy");

        // Walk request pulse during MAIN_G1
        fork
            begin
                repeat (2) @(negedge clk);
                walkRequest = 1'b1;
                repeat (8) @(negedge clk);
                walkRequest = 1'b0;
            end
            runCheck(L_MG, 48, "walk_g");
        join
        runCheck(L_MY, 8, "walk_y");
`ifdef WALK_EN
        runCheck(L_WK, 12, "walk_phase");
`endif
        runCheck(L_SG, 24, "walk_sg");
        runCheck(L_SY, 8,  "walk_sy");
        runCheck(L_MG, 48, "after_g");
        runCheck(L_MY, 8,  "after_y");
        runCheck(L_SG, 24, "after_nowalk_sg");
        runCheck(L_SY, 8,  "after_sy");

        // Sensor pulse at the start of MAIN_G2: G1 24 + G2 12
        fork
            begin
                repeat (24) @(posedge clk);
                #2 trafficSensor = 1'b1;
                repeat (5) @(posedge clk);
                #2 trafficSensor = 1'b0;
            end
            runCheck(L_MG, 36, "g2_sensor");
        join

        // Sensor held across the end of SIDE_G: 24 + 12
        trafficSensor = 1'b1;
        runCheck(L_MY, 8,  "sgext_y");
        runCheck(L_SG, 36, "sgext_sg");
        trafficSensor = 1'b0;
        runCheck(L_SY, 8,  "sgext_sy");

        // Reprogramming: base=3, ext=2, yellow=3
        reprog(2'b00, 4'd3);
        runCheck(L_MG, 24, "base3_g");
        reprog(2'b01, 4'd2);
        runCheck(L_MG, 24, "ext2_g");
        reprog(2'b10, 4'd3);
        runCheck(L_MG, 24, "prog_g");
        runCheck(L_MY, 12, "prog_y");
        runCheck(L_SG, 12, "prog_sg");
        runCheck(L_SY, 12, "prog_sy");
        runCheck(L_MG, 24, "prog_next_g");

        // Extension with reprogrammed ext=2: 12 + 8
        trafficSensor = 1'b1;
        runCheck(L_MY, 12, "ext2_y");
        runCheck(L_SG, 20, "ext2_sg");
        trafficSensor = 1'b0;
        runCheck(L_SY, 12, "ext2_sy");

        // Selector 11 only restarts the sequence
        reprog(2'b11, 4'd9);
        runCheck(L_MG, 24, "sel11_g");
        runCheck(L_MY, 12, "sel11_y");

        // Value 0 is stored as 1 second
        reprog(2'b10, 4'd0);
        runCheck(L_MG, 24, "zero_g");
        runCheck(L_MY, 4,  "zero_y");
        runCheck(L_SG, 12, "zero_sg");

        // Asynchronous reset in the middle of SIDE_Y
        repeat (2) @(posedge clk);
        #3;
        check(int'(lamps), int'(L_SY), "pre_reset_sy");
        reset = 1'b1;
        #1;
        check(int'(lamps), int'(L_MG), "async_reset_lamps");
        @(negedge clk);
        reset = 1'b0;
        #1;
        runCheck(L_MG, 48, "post_reset_g");
        runCheck(L_MY, 8,  "post_reset_y");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
